uart_frame_parser: RTL and testbench
====================================

UART_FRAME_PARSER -- requirements
Module: uart_frame_parser

Interface
REQ-001 SHALL have parameter CLK_FRE, default 96_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BPS, default 9_600, UART baud rate.
REQ-003 SHALL have parameter TIMEOUT_BITS, default 20, inter-byte timeout in bit-times; TIMEOUT_CLKS = (CLK_FRE/BPS)*TIMEOUT_BITS.
REQ-004 SHALL have parameter MAX_LEN, default 16, maximum payload bytes per frame (1..255).
REQ-005 sys_clk  in  1  single clock; all logic on its rising edge.
REQ-006 sys_rst_n  in  1  reset, asynchronous, active-low.
REQ-007 rx_done  in  1  one-cycle byte strobe from UART receiver.
REQ-008 rx_data  in  8  received byte, valid when rx_done=1.
REQ-009 out_valid  out  1  payload byte available.
REQ-010 out_ready  in  1  downstream accepts payload byte.
REQ-011 out_data  out  8  payload byte.
REQ-012 out_last  out  1  marks final payload byte of frame.
REQ-013 frame_cmd  out  8  CMD of last good frame, held until the next good frame.
REQ-014 frame_len  out  8  LEN of last good frame, held until the next good frame.
REQ-015 frame_ok  out  1  one-cycle pulse, good frame accepted.
REQ-016 frame_err  out  1  one-cycle pulse, frame dropped.
REQ-017 err_code  out  3  cause of last error: 1 TIMEOUT, 2 LEN, 3 CHK, 4 OVERRUN; held until the next error.
REQ-018 busy  out  1  high when parser state is not IDLE.

Function
REQ-019 Frame format SHALL be 0x55, 0xAA, CMD, LEN, LEN payload bytes, CHK; CHK = (CMD+LEN+sum payload) mod 256.
REQ-020 Parser FSM states SHALL be IDLE, HDR2, CMD, LEN, DATA, CHK; transitions occur only on rx_done, except the timeout transition.
REQ-021 IDLE: 0x55 -> HDR2; any other byte ignored.
REQ-022 HDR2: 0xAA -> CMD; 0x55 -> stay HDR2 (resync); other -> IDLE, no error.
REQ-023 CMD: latch byte, seed checksum, -> LEN.
REQ-024 LEN: 0 or >MAX_LEN -> IDLE, frame_err, err_code=2; else latch, -> DATA.
REQ-025 DATA: write byte to buffer at index 0..LEN-1, accumulate checksum; after byte LEN -> CHK.
REQ-026 CHK: match -> IDLE, frame_ok, update frame_cmd/frame_len, start drain; mismatch -> IDLE, frame_err, err_code=3, buffer discarded.
REQ-027 Timeout counter SHALL clear on every rx_done and in IDLE; reaching TIMEOUT_CLKS outside IDLE -> IDLE, frame_err, err_code=1; rx_done in the same cycle wins.
REQ-028 Drain: out_valid rises the cycle after the CHK byte's rx_done; one byte transfers per cycle with out_valid&&out_ready; out_data/out_last stable while stalled; out_valid drops after the last transfer.
REQ-029 0x55 received in IDLE while drain is active SHALL be dropped: frame_err, err_code=4, stay IDLE.
REQ-030 Checksum and length arithmetic SHALL be 8-bit, wrapping modulo 256.
REQ-031 frame_ok and frame_err SHALL never assert in the same cycle.

Reset
REQ-032 Reset SHALL force state IDLE, drain idle, all counters and pointers 0, all outputs 0.
REQ-033 Assertion mid-frame or mid-drain SHALL discard all partial and buffered data; no pulses follow reset.

Structure
REQ-034 A shared package uart_pkg SHALL hold SOF constants 0x55/0xAA, err_code values and FSM state encoding.
REQ-035 Payload storage SHALL be sub-module uart_frame_buf: MAX_LEN x 8 registers, write port plus read pointer, with a combinational read.

Verification
REQ-036 55 AA 01 02 10 20 33, out_ready=1 -> frame_ok, frame_cmd=01, frame_len=02, out 10 then 20 with out_last on 20.
REQ-037 Same frame with CHK=34 -> frame_err, err_code=3, out_valid never asserts.
REQ-038 55 AA 01 then silence > TIMEOUT_CLKS -> frame_err, err_code=1, busy=0.
REQ-039 LEN=MAX_LEN+1 -> err_code=2; 55 55 AA 01 01 7F 81 -> frame_ok (resync).
REQ-040 out_ready=0 during drain, new 55 arrives -> err_code=4, out_data held; reset pulse mid-DATA -> all outputs 0, next good frame accepted.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants, error codes and parser state encoding for the UART frame parser.
package uart_pkg;

  localparam logic [7:0] SOF1 = 8'h55;
  localparam logic [7:0] SOF2 = 8'hAA;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_TIMEOUT = 3'd1;
  localparam logic [2:0] ERR_LEN     = 3'd2;
  localparam logic [2:0] ERR_CHK     = 3'd3;
  localparam logic [2:0] ERR_OVERRUN = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR2 = 3'd1,
    ST_CMD  = 3'd2,
    ST_LEN  = 3'd3,
    ST_DATA = 3'd4,
    ST_CHK  = 3'd5
  } state_e;

  // Index width for a buffer of 'depth' entries, never below one bit.
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// Payload buffer: MAX_LEN byte registers with one write port and a combinational read.
module uart_frame_buf
  import uart_pkg::*;
#(
  parameter int MAX_LEN = 16,
  parameter int AW      = idx_width(MAX_LEN)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem [MAX_LEN];

  for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_entry
    logic [7:0] entry_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        entry_q <= 8'h00;
      end else if (we_i && (waddr_i == AW'(gi))) begin
        entry_q <= wdata_i;
      end
    end

    assign mem[gi] = entry_q;
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/uart_frame_parser.sv
// Parses 55 AA CMD LEN payload CHK frames from a UART byte stream and drains
// each verified payload over a valid/ready interface.
module uart_frame_parser
  import uart_pkg::*;
#(
  parameter int CLK_FRE      = 96_000_000,
  parameter int BPS          = 9_600,
  parameter int TIMEOUT_BITS = 20,
  parameter int MAX_LEN      = 16
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       rx_done,
  input  logic [7:0] rx_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic [7:0] frame_cmd,
  output logic [7:0] frame_len,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [2:0] err_code,
  output logic       busy
);

  localparam int          AW           = idx_width(MAX_LEN);
  localparam int          TIMEOUT_CLKS = (CLK_FRE / BPS) * TIMEOUT_BITS;
  localparam logic [31:0] TMO_LAST     = 32'(TIMEOUT_CLKS - 1);
  localparam logic [7:0]  MAX_LEN_B    = 8'(MAX_LEN);

  state_e          state_q, state_d;
  logic [7:0]      cmd_q, cmd_d;
  logic [7:0]      len_q, len_d;
  logic [7:0]      chk_q, chk_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [31:0]     tmo_q, tmo_d;
  logic [7:0]      frame_cmd_q, frame_cmd_d;
  logic [7:0]      frame_len_q, frame_len_d;
  logic            ok_q, ok_d;
  logic            err_q, err_d;
  logic [2:0]      err_code_q, err_code_d;
  logic            drain_q, drain_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;

  logic            buf_we;
  logic [AW-1:0]   buf_waddr;
  logic [7:0]      buf_rdata;
  logic            drain_last;

  assign buf_we     = rx_done && (state_q == ST_DATA);
  assign buf_waddr  = cnt_q[AW-1:0];
  assign drain_last = (8'(rd_ptr_q) == (frame_len_q - 8'd1));

  uart_frame_buf #(
    .MAX_LEN (MAX_LEN),
    .AW      (AW)
  ) u_buf (
    .clk_i   (sys_clk),
    .rst_ni  (sys_rst_n),
    .we_i    (buf_we),
    .waddr_i (buf_waddr),
    .wdata_i (rx_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (buf_rdata)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= ST_IDLE;
      cmd_q       <= 8'h00;
      len_q       <= 8'h00;
      chk_q       <= 8'h00;
      cnt_q       <= 8'h00;
      tmo_q       <= 32'd0;
      frame_cmd_q <= 8'h00;
      frame_len_q <= 8'h00;
      ok_q        <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= ERR_NONE;
      drain_q     <= 1'b0;
      rd_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      len_q       <= len_d;
      chk_q       <= chk_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      frame_cmd_q <= frame_cmd_d;
      frame_len_q <= frame_len_d;
      ok_q        <= ok_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      drain_q     <= drain_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    len_d       = len_q;
    chk_d       = chk_q;
    cnt_d       = cnt_q;
    frame_cmd_d = frame_cmd_q;
    frame_len_d = frame_len_q;
    ok_d        = 1'b0;
    err_d       = 1'b0;
    err_code_d  = err_code_q;
    drain_d     = drain_q;
    rd_ptr_d    = rd_ptr_q;
    tmo_d       = (state_q == ST_IDLE || rx_done) ? 32'd0 : tmo_q + 32'd1;

    if (drain_q && out_ready) begin
      if (drain_last) begin
        drain_d  = 1'b0;
        rd_ptr_d = '0;
      end else begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
    end

    if (rx_done) begin
      unique case (state_q)
        ST_IDLE: begin
          // A new frame would overwrite the buffer still being drained.
          if (rx_data == SOF1) begin
            if (drain_q) begin
              err_d      = 1'b1;
              err_code_d = ERR_OVERRUN;
            end else begin
              state_d = ST_HDR2;
            end
          end
        end
        ST_HDR2: begin
          if (rx_data == SOF2) begin
            state_d = ST_CMD;
          end else if (rx_data != SOF1) begin
            state_d = ST_IDLE;
          end
        end
        ST_CMD: begin
          cmd_d   = rx_data;
          chk_d   = rx_data;
          state_d = ST_LEN;
        end
        ST_LEN: begin
          if (rx_data == 8'h00 || rx_data > MAX_LEN_B) begin
            state_d    = ST_IDLE;
            err_d      = 1'b1;
            err_code_d = ERR_LEN;
          end else begin
            len_d   = rx_data;
            chk_d   = chk_q + rx_data;
            cnt_d   = 8'h00;
            state_d = ST_DATA;
          end
        end
        ST_DATA: begin
          chk_d = chk_q + rx_data;
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == len_q - 8'd1) begin
            state_d = ST_CHK;
          end
        end
        ST_CHK: begin
          state_d = ST_IDLE;
          if (rx_data == chk_q) begin
            ok_d        = 1'b1;
            frame_cmd_d = cmd_q;
            frame_len_d = len_q;
            drain_d     = 1'b1;
            rd_ptr_d    = '0;
          end else begin
            err_d      = 1'b1;
            err_code_d = ERR_CHK;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE && tmo_q >= TMO_LAST) begin
      state_d    = ST_IDLE;
      err_d      = 1'b1;
      err_code_d = ERR_TIMEOUT;
    end
  end

  assign out_valid = drain_q;
  assign out_data  = drain_q ? buf_rdata : 8'h00;
  assign out_last  = drain_q && drain_last;
  assign frame_cmd = frame_cmd_q;
  assign frame_len = frame_len_q;
  assign frame_ok  = ok_q;
  assign frame_err = err_q;
  assign err_code  = err_code_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_frame_parser.sv
// Scoreboard bench: a stream-level frame model predicts events and payload bytes,
// a monitor checks them as the parser presents them.
`timescale 1ns/1ps
module tb_uart_frame_parser;

  localparam int CLK_FRE      = 1000;
  localparam int BPS          = 100;
  localparam int TIMEOUT_BITS = 3;
  localparam int MAX_LEN      = 8;
  localparam int TIMEOUT_CLKS = (CLK_FRE / BPS) * TIMEOUT_BITS;
  localparam int SILENCE      = TIMEOUT_CLKS + 10;

  logic       sys_clk   = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       rx_done   = 1'b0;
  logic [7:0] rx_data   = 8'h00;
  logic       out_ready = 1'b0;
  logic       out_valid, out_last, frame_ok, frame_err, busy;
  logic [7:0] out_data, frame_cmd, frame_len;
  logic [2:0] err_code;

  typedef struct {
    bit         ok;
    logic [2:0] code;
    logic [7:0] cmd;
    logic [7:0] len;
  } ev_t;

  typedef struct {
    logic [7:0] data;
    bit         last;
  } pl_t;

  typedef logic [7:0] bq_t[$];

  ev_t ev_q[$];
  pl_t pl_q[$];
  int  compared   = 0;
  int  mismatched = 0;
  bit  rand_ready = 1'b0;

  uart_frame_parser #(
    .CLK_FRE      (CLK_FRE),
    .BPS          (BPS),
    .TIMEOUT_BITS (TIMEOUT_BITS),
    .MAX_LEN      (MAX_LEN)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .rx_done   (rx_done),
    .rx_data   (rx_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .frame_cmd (frame_cmd),
    .frame_len (frame_len),
    .frame_ok  (frame_ok),
    .frame_err (frame_err),
    .err_code  (err_code),
    .busy      (busy)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    rx_data = 8'($urandom);
  endtask

  task automatic send_burst(input bq_t bs);
    foreach (bs[k]) begin
      send_byte(bs[k]);
      repeat ($urandom_range(0, 4)) tick();
    end
  endtask

  task automatic push_err(input logic [2:0] code);
    ev_q.push_back('{ok: 1'b0, code: code, cmd: 8'h00, len: 8'h00});
  endtask

  // Frame rules applied to a whole burst of bytes; the burst is always followed
  // by silence, so an unfinished frame ends in a timeout.
  task automatic model_burst(input bq_t bs);
    int i;
    int n;
    int total;
    int cmd;
    int len;
    i = 0;
    n = bs.size();
    while (i < n) begin
      if (bs[i] != 8'h55) begin
        i++;
        continue;
      end
      i++;
      while (i < n && bs[i] == 8'h55) i++;
      if (i >= n) begin push_err(3'd1); return; end
      if (bs[i] != 8'hAA) begin
        i++;
        continue;
      end
      if (i + 2 >= n) begin push_err(3'd1); return; end
      cmd = int'(bs[i+1]);
      len = int'(bs[i+2]);
      i += 3;
      if (len == 0 || len > MAX_LEN) begin
        push_err(3'd2);
        continue;
      end
      if (i + len >= n) begin push_err(3'd1); return; end
      total = cmd + len;
      for (int k = 0; k < len; k++) total += int'(bs[i+k]);
      if (int'(bs[i+len]) == total % 256) begin
        ev_q.push_back('{ok: 1'b1, code: 3'd0, cmd: 8'(cmd), len: 8'(len)});
        for (int k = 0; k < len; k++) pl_q.push_back('{data: bs[i+k], last: (k == len - 1)});
      end else begin
        push_err(3'd3);
      end
      i += len + 1;
    end
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 200; k++) begin
      if (!out_valid) break;
      tick();
    end
    check("drain_done", out_valid, 1'b0);
  endtask

  task automatic run_frame(input bq_t bs);
    model_burst(bs);
    send_burst(bs);
    repeat (SILENCE) tick();
    wait_drain();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_out_last"}, out_last, 0);
    check({tag, "_frame_cmd"}, frame_cmd, 0);
    check({tag, "_frame_len"}, frame_len, 0);
    check({tag, "_frame_ok"}, frame_ok, 0);
    check({tag, "_frame_err"}, frame_err, 0);
    check({tag, "_err_code"}, err_code, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  task automatic random_burst(input int idx);
    bq_t        bs;
    int         kind;
    int         len;
    int         total;
    logic [7:0] b;
    logic [7:0] cmd;
    kind = $urandom_range(0, 5);
    repeat ($urandom_range(0, 3)) begin
      b = 8'($urandom);
      if (b == 8'h55) b = 8'h00;
      bs.push_back(b);
    end
    if (kind == 4) bs.push_back(8'h55);
    if (kind == 5) begin
      b = 8'($urandom);
      if (b == 8'h55 || b == 8'hAA) b = 8'h12;
      bs.push_back(8'h55);
      bs.push_back(b);
    end
    cmd = 8'($urandom);
    bs.push_back(8'h55);
    bs.push_back(8'hAA);
    bs.push_back(cmd);
    if (kind == 2) begin
      bs.push_back(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAX_LEN + 1, 255)));
    end else begin
      len = $urandom_range(1, MAX_LEN);
      bs.push_back(8'(len));
      total = int'(cmd) + len;
      for (int k = 0; k < len; k++) begin
        b = 8'($urandom);
        total += int'(b);
        bs.push_back(b);
      end
      b = 8'(total % 256);
      if (kind == 1) b = b ^ (8'h01 << $urandom_range(0, 7));
      bs.push_back(b);
      if (kind == 3) repeat ($urandom_range(1, len + 3)) void'(bs.pop_back());
    end
    model_burst(bs);
    $display("burst %0d kind=%0d bytes=%0d expected_events=%0d", idx, kind, bs.size(), ev_q.size());
    send_burst(bs);
    repeat (SILENCE) tick();
    wait_drain();
    check("idle_after_burst", busy, 1'b0);
  endtask

  // Monitor: consumes one expectation each time the parser reports an event or a byte.
  initial begin
    ev_t e;
    pl_t p;
    forever begin
      @(negedge sys_clk);
      if (frame_ok || frame_err) begin
        check("ok_err_exclusive", frame_ok & frame_err, 1'b0);
        if (ev_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_event: got ok=%0b err=%0b code=%0d, required no event",
                   frame_ok, frame_err, err_code);
        end else begin
          e = ev_q.pop_front();
          $display("event ok=%0b err=%0b code=%0d cmd=%02h len=%0d", frame_ok, frame_err,
                   err_code, frame_cmd, frame_len);
          check("event_ok", frame_ok, e.ok);
          check("event_err", frame_err, !e.ok);
          if (e.ok) begin
            check("frame_cmd", frame_cmd, e.cmd);
            check("frame_len", frame_len, e.len);
          end else begin
            check("err_code", err_code, e.code);
          end
        end
      end
      if (out_valid && out_ready) begin
        if (pl_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_byte: got data=%02h last=%0b, required none", out_data, out_last);
        end else begin
          p = pl_q.pop_front();
          $display("byte data=%02h last=%0b", out_data, out_last);
          check("out_data", out_data, p.data);
          check("out_last", out_last, p.last);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no end of run, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tick();
    tick();
    check_all_zero("reset");
    sys_rst_n = 1'b1;
    tick();
    out_ready = 1'b1;

    run_frame('{8'h55, 8'hAA, 8'h01, 8'h02, 8'h10, 8'h20, 8'h33});
    check("good_frame_cmd", frame_cmd, 8'h01);
    check("good_frame_len", frame_len, 8'h02);

    run_frame('{8'h55, 8'hAA, 8'h01, 8'h02, 8'h10, 8'h20, 8'h34});
    check("bad_chk_code", err_code, 3'd3);

    run_frame('{8'h55, 8'hAA, 8'h01});
    check("timeout_code", err_code, 3'd1);
    check("timeout_busy", busy, 1'b0);

    run_frame('{8'h55, 8'hAA, 8'h01, 8'(MAX_LEN + 1)});
    check("len_code", err_code, 3'd2);

    run_frame('{8'h55, 8'h55, 8'hAA, 8'h01, 8'h01, 8'h7F, 8'h81});
    check("resync_len", frame_len, 8'h01);

    // Stalled drain, then a new start byte arrives.
    out_ready = 1'b0;
    model_burst('{8'h55, 8'hAA, 8'h01, 8'h02, 8'h10, 8'h20, 8'h33});
    send_burst('{8'h55, 8'hAA, 8'h01, 8'h02, 8'h10, 8'h20, 8'h33});
    repeat (3) tick();
    push_err(3'd4);
    send_byte(8'h55);
    repeat (3) tick();
    check("overrun_code", err_code, 3'd4);
    check("overrun_busy", busy, 1'b0);
    check("stall_valid", out_valid, 1'b1);
    check("stall_data", out_data, 8'h10);
    check("stall_last", out_last, 1'b0);
    out_ready = 1'b1;
    wait_drain();

    // Reset in the middle of a payload.
    send_burst('{8'h55, 8'hAA, 8'h01, 8'h04, 8'h11, 8'h22});
    sys_rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    tick();
    tick();
    sys_rst_n = 1'b1;
    tick();
    run_frame('{8'h55, 8'hAA, 8'h01, 8'h01, 8'h7F, 8'h81});
    check("post_reset_len", frame_len, 8'h01);

    rand_ready = 1'b1;
    for (int n = 0; n < 60; n++) random_burst(n);
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    repeat (4) tick();

    check("events_left", ev_q.size(), 0);
    check("bytes_left", pl_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
